// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit saturating-count debouncer for board switches.
// Define SWITCH_DEBOUNCE_EDGE_EN to get per-bit rise/fall pulses; otherwise they read 0.
module switch_debouncer #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] debounced,
  output logic             changed,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] debounced_reg;
  logic [WIDTH-1:0] update;
  logic             changed_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= switches_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // The counter reaching CNT_MAX while still mismatched is the DEBOUNCE_CYCLES-th
  // consecutive mismatch, so the update fires on that same edge and the count restarts.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] cnt_reg;
    logic          mismatch;

    assign mismatch   = sync2_reg[gi] != debounced_reg[gi];
    assign update[gi] = mismatch && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg <= '0;
      end else if (!mismatch || update[gi]) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced_reg <= '0;
      changed_reg   <= 1'b0;
    end else begin
      debounced_reg <= (debounced_reg & ~update) | (sync2_reg & update);
      changed_reg   <= |update;
    end
  end

  assign debounced = debounced_reg;
  assign changed   = changed_reg;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  // Registered on the update edge so pulses line up with the new debounced value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= update & sync2_reg;
      fall_reg <= update & ~sync2_reg;
    end
  end

  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer at WIDTH=18, DEBOUNCE_CYCLES=4.
// Expected pulses follow SWITCH_DEBOUNCE_EDGE_EN; without it rise/fall must stay 0.
module tb_switch_debouncer;
  localparam int W  = 18;
  localparam int DC = 4;
  localparam int UPD = DC + 2;  // tick index (1 = capture edge) at which debounced updates
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] switches_raw = '0;
  logic [W-1:0] debounced;
  logic         changed;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [3*W:0] obs;
  logic [3*W:0] exp_v;
  int errors = 0;
  int checks = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .switches_raw(switches_raw),
    .debounced(debounced), .changed(changed),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;
  assign obs = {debounced, changed, rise_pulse, fall_pulse};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {debounced, changed, rise, fall} k ticks after a raw step old_v -> new_v.
  function automatic logic [3*W:0] model(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                         input int k);
    logic [W-1:0] d, r, f;
    logic c;
    d = (k >= UPD) ? new_v : old_v;
    c = (k == UPD) && (new_v != old_v);
    r = c ? (new_v & ~old_v) : '0;
    f = c ? (old_v & ~new_v) : '0;
    if (!EDGE_EN) begin
      r = '0;
      f = '0;
    end
    return {d, c, r, f};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    switches_raw = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) reset_n = 1'b1;
      tick();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset k=%0d got %h want 0", k, obs);
      end
    end
  endtask

  task automatic test_step(input string name, input logic [W-1:0] old_v, input logic [W-1:0] new_v);
    switches_raw = new_v;
    for (int k = 1; k <= UPD + 2; k++) begin
      tick();
      exp_v = model(old_v, new_v, k);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s k=%0d got %h want %h", name, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    switches_raw = 18'h00001;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) switches_raw = '0;
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL glitch k=%0d got %h want 0", k, obs);
      end
    end
  endtask

  task automatic test_min_pulse();
    switches_raw = 18'h00001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) switches_raw = '0;
      exp_v = (k < 10) ? model('0, 18'h00001, k) : model(18'h00001, '0, k - 4);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL min_pulse k=%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_high();
    reset_n = 1'b0;
    switches_raw = 18'h3FFFF;
    for (int k = 1; k <= 3; k++) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= UPD + 2; k++) begin
      tick();
      exp_v = model('0, 18'h3FFFF, k);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_high k=%0d got %h want %h", k, obs, exp_v);
      end
    end
    // Asynchronous clear of a settled all-ones value.
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_clear got %h want 0", obs);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    // Short reset pulse mid-count; the count restarts from the next sampling edge.
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL midcount_clear got %h want 0", obs);
    end
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= UPD + 2; k++) begin
      tick();
      exp_v = model('0, 18'h3FFFF, k);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL midcount_restart k=%0d got %h want %h", k, obs, exp_v);
      end
    end
    test_step("all_fall", 18'h3FFFF, '0);
  endtask

  initial begin
    test_reset();
    test_step("rise_bit3", '0, 18'h00008);
    test_step("fall_bit3", 18'h00008, '0);
    test_glitch();
    test_min_pulse();
    test_step("rise_b17_b0", '0, 18'h20001);
    test_step("mixed", 18'h20001, 18'h00102);
    test_step("fall_all", 18'h00102, '0);
    test_reset_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 18; number of switch bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000; cycles a synchronized bit must differ from its debounced value before the debounced value updates; legal range 2..2^20.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port switches_raw  input  WIDTH  raw asynchronous switch levels from the board pins.
REQ-006 SHALL have port debounced  output  WIDTH  synchronized, debounced switch levels; feeds the PIO in_port of the switch input stage.
REQ-007 SHALL have port changed  output  1  one-cycle pulse when any debounced bit updates.
REQ-008 SHALL have port rise_pulse  output  WIDTH  per-bit one-cycle pulse on a debounced 0->1 update.
REQ-009 SHALL have port fall_pulse  output  WIDTH  per-bit one-cycle pulse on a debounced 1->0 update.

Function
REQ-010 SHALL pass each bit of switches_raw through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-011 SHALL keep one counter per bit, width ceil(log2(DEBOUNCE_CYCLES)), with all bits processed independently and in parallel.
REQ-012 SHALL increment a bit's counter on each edge where sync2 differs from debounced, and clear it on each edge where they are equal.
REQ-013 SHALL, on an edge where sync2 differs from debounced and the counter equals DEBOUNCE_CYCLES-1, load debounced with sync2 and clear the counter.
REQ-014 SHALL give a latency of exactly DEBOUNCE_CYCLES+1 rising edges from the edge that captures a stable change into sync1 to the edge that updates debounced.
REQ-015 SHALL discard any mismatch run shorter than DEBOUNCE_CYCLES cycles: one equal cycle clears the counter, debounced is unchanged, and no pulse is issued.
REQ-016 SHALL never let a counter exceed DEBOUNCE_CYCLES-1 and SHALL never wrap it.
REQ-017 SHALL register changed high for exactly the cycle following the edge of any debounced update, and low otherwise.
REQ-018 SHALL assert changed for only one cycle when several bits update on the same edge, with each such bit pulsing its own rise_pulse or fall_pulse in that same cycle.
REQ-019 SHALL keep rise_pulse, fall_pulse and changed registered and aligned to the cycle in which the new debounced value is first visible.
REQ-020 SHALL drive debounced from registers only, with no combinational path from switches_raw to any output.

Reset
REQ-021 SHALL, while reset_n is low, asynchronously force sync1, sync2, debounced, all counters, changed, rise_pulse and fall_pulse to 0.
REQ-022 SHALL, on reset_n deassertion with switches held high, update those debounced bits DEBOUNCE_CYCLES+1 edges after the first edge that samples them, issuing the matching rise_pulse and changed pulses.
REQ-023 SHALL, if reset asserts mid-count, abandon the count and issue no pulse.

Configuration
REQ-024 SHALL implement per-bit edge detection only when macro SWITCH_DEBOUNCE_EDGE_EN is defined; rise_pulse and fall_pulse then behave per REQ-008/009/018.
REQ-025 SHALL, when SWITCH_DEBOUNCE_EDGE_EN is undefined, keep the rise_pulse and fall_pulse ports but tie them to 0, while debounced and changed keep identical behaviour.

Verification (WIDTH=18, DEBOUNCE_CYCLES=4)
REQ-026 SHALL cover: reset with switches_raw=0x00000 -> debounced=0x00000, changed=0, and all pulses 0 through 20 cycles.
REQ-027 SHALL cover: bit 3 steps 0->1, captured into sync1 at edge E -> debounced=0x00008 after edge E+5, with changed and rise_pulse[3] high for that one cycle only.
REQ-028 SHALL cover: bit 0 glitches high for 3 cycles, then returns low -> debounced stays 0x00000 and no pulse is issued.
REQ-029 SHALL cover: bits 17 and 0 rise in the same cycle -> debounced=0x20001 after 5 edges, with a single changed pulse and rise_pulse=0x20001.
REQ-030 SHALL cover: switches_raw=0x3FFFF held through reset release -> debounced=0x3FFFF 5 edges after the first sampling edge; a reset pulse during a count yields debounced=0 and no pulse.
REQ-031 SHALL cover: build without SWITCH_DEBOUNCE_EDGE_EN and repeat REQ-027 -> debounced and changed unchanged, with rise_pulse and fall_pulse constantly 0.
